// File: rtl/memory_access_pkg.sv
// memory_access shared types and helpers:
// FSM states, access sizes, alignment, lanes, load extension.
package memory_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic ok;
    ok = (off == 2'b00);
    if (size == SIZE_BYTE) ok = 1'b1;
    else if (size == SIZE_HALF) ok = ~off[0];
    return ok;
  endfunction

  function automatic logic [3:0] lane_enable(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    if (size == SIZE_BYTE) be = 4'b0001 << off;
    else if (size == SIZE_HALF) be = off[1] ? 4'b1100 : 4'b0011;
    return be;
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = d;
    if (size == SIZE_BYTE) r = {4{d[7:0]}};
    else if (size == SIZE_HALF) r = {2{d[15:0]}};
    return r;
  endfunction

  function automatic logic [31:0] load_extend(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    r = w;
    if (size == SIZE_BYTE) r = {{24{sgn & b[7]}}, b};
    else if (size == SIZE_HALF) r = {{16{sgn & h[15]}}, h};
    return r;
  endfunction

endpackage

// File: rtl/memory_access_data_ram.sv
// Data memory: 32-bit words, byte-enable write,
// registered read, contents survive reset.
module data_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [AW-1:0] raddr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/memory_access.sv
// MEM-stage load/store unit: wait-stated data memory
// access, load extension and pipeline stall.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memSigned,
  input  logic [4:0]  writeRegister,
  input  logic        regWrite,
  input  logic        memToReg,
  output logic [31:0] aluOut,
  output logic [31:0] memoryOut,
  output logic [4:0]  writeRegisterOut,
  output logic        regWriteOut,
  output logic        memToRegOut,
  output logic        stall,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic          wr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [AW-1:0] idx_q;

  logic          req;
  logic          aligned;
  logic          go;
  logic          commit;
  logic [AW-1:0] idx;
  logic [AW-1:0] raddr;
  logic [31:0]   ram_rdata;
  logic          unused_addr;

  assign req     = memRead | memWrite;
  assign aligned = is_aligned(memSize, aluResult[1:0]);
  assign go      = (state_q == IDLE) & req & aligned;
  assign commit  = (state_q == WAIT) & (cnt_q == 4'd0);
  assign idx     = aluResult[AW+1:2];
  assign unused_addr = ^aluResult[31:AW+2];

  // Address the RAM early so the read word is ready by the commit edge.
  assign raddr = (state_q == IDLE) ? idx : idx_q;

  data_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (commit & wr_q),
    .be_i   (be_q),
    .waddr_i(idx_q),
    .raddr_i(raddr),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      off_q   <= 2'b00;
      size_q  <= SIZE_BYTE;
      sgn_q   <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_q <= WAIT;
            cnt_q   <= 4'(WAIT_STATES);
            off_q   <= aluResult[1:0];
            size_q  <= memSize;
            sgn_q   <= memSigned;
            wr_q    <= memWrite;
            be_q    <= lane_enable(memSize, aluResult[1:0]);
            wdata_q <= lane_data(memSize, writeData);
            idx_q   <= idx;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!wr_q) rdata_q <= load_extend(ram_rdata, off_q, size_q, sgn_q);
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = go | (state_q == WAIT);
  assign misaligned = (state_q == IDLE) & req & ~aligned;
  assign memoryOut  = rdata_q;

  assign aluOut           = aluResult;
  assign writeRegisterOut = writeRegister;
  assign memToRegOut      = memToReg;
  assign regWriteOut      = regWrite & ~(misaligned & ~memWrite);

endmodule

// File: tb/tb_memory_access.sv
// Randomised bench for memory_access against a byte-array
// reference model, plus directed literal scenarios.
module tb_memory_access;

  localparam int WS    = 1;
  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] aluResult = '0;
  logic [31:0] writeData = '0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [1:0]  memSize = '0;
  logic        memSigned = 1'b0;
  logic [4:0]  writeRegister = '0;
  logic        regWrite = 1'b0;
  logic        memToReg = 1'b0;
  logic [31:0] aluOut;
  logic [31:0] memoryOut;
  logic [4:0]  writeRegisterOut;
  logic        regWriteOut;
  logic        memToRegOut;
  logic        stall;
  logic        misaligned;

  memory_access #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .aluResult       (aluResult),
    .writeData       (writeData),
    .memRead         (memRead),
    .memWrite        (memWrite),
    .memSize         (memSize),
    .memSigned       (memSigned),
    .writeRegister   (writeRegister),
    .regWrite        (regWrite),
    .memToReg        (memToReg),
    .aluOut          (aluOut),
    .memoryOut       (memoryOut),
    .writeRegisterOut(writeRegisterOut),
    .regWriteOut     (regWriteOut),
    .memToRegOut     (memToRegOut),
    .stall           (stall),
    .misaligned      (misaligned)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: byte-addressed memory and a cycle count
  // since the request was accepted (0 = no access in flight).
  bit [7:0]    mb [DEPTH*4];
  int          m_cnt = 0;
  logic [31:0] exp_out = '0;
  logic [31:0] c_addr, c_data;
  logic [1:0]  c_size;
  bit          c_sgn, c_wr;
  int          base, n;
  logic [31:0] v;

  function automatic bit al(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'd0) return 1'b1;
    if (s == 2'd1) return a[0] == 1'b0;
    return a[1:0] == 2'b00;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cnt   = 0;
      exp_out = '0;
    end else if (m_cnt == 0) begin
      if ((memRead || memWrite) && al(memSize, aluResult)) begin
        c_addr = aluResult;
        c_data = writeData;
        c_size = memSize;
        c_sgn  = memSigned;
        c_wr   = memWrite;
        m_cnt  = 1;
      end
    end else if (m_cnt == WS + 1) begin
      base = int'(c_addr % (DEPTH * 4));
      n    = nbytes(c_size);
      if (c_wr) begin
        for (int i = 0; i < n; i++) mb[base+i] = c_data[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base+i];
        if (c_sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        exp_out = v;
      end
      m_cnt = m_cnt + 1;
    end else if (m_cnt == WS + 2) begin
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
  end

  bit rq_e, al_e, mis_e, stl_e, rw_e;

  always @(negedge clock) begin
    rq_e  = memRead || memWrite;
    al_e  = al(memSize, aluResult);
    mis_e = (m_cnt == 0) && rq_e && !al_e;
    stl_e = ((m_cnt == 0) && rq_e && al_e) || (m_cnt >= 1 && m_cnt <= WS + 1);
    rw_e  = regWrite && !(mis_e && !memWrite);
    chk("aluOut", aluOut, aluResult);
    chk("writeRegisterOut", 32'(writeRegisterOut), 32'(writeRegister));
    chk("memToRegOut", 32'(memToRegOut), 32'(memToReg));
    chk("regWriteOut", 32'(regWriteOut), 32'(rw_e));
    chk("misaligned", 32'(misaligned), 32'(mis_e));
    chk("stall", 32'(stall), 32'(stl_e));
    chk("memoryOut", memoryOut, exp_out);
  end

  // Issue one instruction and hold it until the access completes;
  // returns at the sampling point of its final (non-stalled) cycle.
  task automatic op(input bit rd, input bit wr, input logic [1:0] sz,
                    input bit sg, input logic [31:0] a,
                    input logic [31:0] d, output int stalls);
    @(posedge clock);
    #1;
    memRead       = rd;
    memWrite      = wr;
    memSize       = sz;
    memSigned     = sg;
    aluResult     = a;
    writeData     = d;
    writeRegister = 5'($urandom);
    regWrite      = !wr;
    memToReg      = rd;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (stall) stalls++;
      else break;
    end
    if (stalls >= 40) chk("stall_bound", 32'(stalls), 32'd0);
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC010_A030 + 32'h0101_0101 * i;
  endfunction

  int s;
  int kind;

  initial begin
    #2 reset = 1'b0;
    @(negedge clock);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_memoryOut", memoryOut, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < 16; i++) op(0, 1, 2'd2, 0, 32'(i * 4), init_word(i), s);

    op(0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, s);
    chk("sw_stall_cycles", 32'(s), 32'd3);
    op(1, 0, 2'd2, 0, 32'h10, 32'h0, s);
    chk("lw_stall_cycles", 32'(s), 32'd3);
    chk("lw_10", memoryOut, 32'hDEAD_BEEF);
    chk("lw_regWriteOut", 32'(regWriteOut), 32'd1);

    op(0, 1, 2'd0, 0, 32'h13, 32'h80, s);
    op(1, 0, 2'd0, 1, 32'h13, 32'h0, s);
    chk("lb_13", memoryOut, 32'hFFFF_FF80);
    op(1, 0, 2'd0, 0, 32'h13, 32'h0, s);
    chk("lbu_13", memoryOut, 32'h0000_0080);
    op(1, 0, 2'd2, 0, 32'h10, 32'h0, s);
    chk("lw_after_sb", memoryOut, 32'h80AD_BEEF);

    op(0, 1, 2'd1, 0, 32'h12, 32'h1234, s);
    op(1, 0, 2'd1, 1, 32'h12, 32'h0, s);
    chk("lh_12", memoryOut, 32'h0000_1234);
    op(1, 0, 2'd1, 0, 32'h12, 32'h0, s);
    chk("lhu_12", memoryOut, 32'h0000_1234);
    op(1, 0, 2'd1, 1, 32'h11, 32'h0, s);
    chk("lh_11_misaligned", 32'(misaligned), 32'd1);
    chk("lh_11_stall", 32'(s), 32'd0);
    chk("lh_11_regWriteOut", 32'(regWriteOut), 32'd0);
    op(1, 0, 2'd2, 0, 32'h10, 32'h0, s);
    chk("lw_after_sh", memoryOut, 32'h1234_BEEF);

    op(1, 1, 2'd2, 0, 32'h20, 32'h55, s);
    chk("rw_both_stall", 32'(s), 32'd3);
    op(1, 0, 2'd2, 0, 32'h20, 32'h0, s);
    chk("lw_20", memoryOut, 32'h0000_0055);
    op(1, 0, 2'd2, 0, 32'h420, 32'h0, s);
    chk("lw_420_alias", memoryOut, 32'h0000_0055);

    @(posedge clock);
    #1;
    memRead   = 1'b0;
    memWrite  = 1'b1;
    memSize   = 2'd2;
    aluResult = 32'h30;
    writeData = 32'h0000_AAAA;
    @(posedge clock);
    #1;
    memWrite = 1'b0;
    reset    = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_memoryOut", memoryOut, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    op(1, 0, 2'd2, 0, 32'h30, 32'h0, s);
    chk("lw_30_after_drop", memoryOut, 32'hCC1C_AC3C);

    op(0, 0, 2'd0, 0, 32'h1234_5678, 32'h0, s);
    chk("add_stall", 32'(s), 32'd0);
    chk("add_aluOut", aluOut, 32'h1234_5678);
    chk("add_regWriteOut", 32'(regWriteOut), 32'd1);

    for (int t = 0; t < 300; t++) begin
      kind = int'($urandom_range(0, 3));
      op(kind == 1 || kind == 3, kind >= 2, 2'($urandom), 1'($urandom),
         ($urandom & 32'hFFFF_FC00) | ($urandom & 32'h0000_003F),
         $urandom, s);
    end

    @(posedge clock);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
    @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
